// File: rtl/sram_fifo_ctrl_pkg.sv
// Shared definitions for the SRAM-backed FWFT FIFO controller: port-mode
// encodings, prefetch depth and width helpers for pointers and counters.
package sram_fifo_ctrl_pkg;

   // Bank port configuration encodings for the DUAL_PORT parameter
   localparam int DUAL_PORT_OFF = 0;
   localparam int DUAL_PORT_ON  = 1;

   // Number of words the prefetch buffer can hold ahead of the consumer
   localparam int OB_DEPTH = 2;

   // Bank address width for a given depth (at least one bit)
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Occupancy counter width: bank words plus in-flight read plus prefetch
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 3);
   endfunction

endpackage

// File: rtl/sram_fifo_prefetch.sv
// Two-entry skid FIFO that catches bank read data and presents the head word.
// Head register drives the consumer directly so out_data is always registered.
module sram_fifo_prefetch
   import sram_fifo_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic [1:0]            cnt
);

   logic [DATA_WIDTH-1:0] head_r;
   logic [DATA_WIDTH-1:0] tail_r;
   logic [1:0]            cnt_r;

   // Entry storage and fill level; simultaneous push and pop keep the level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_r <= {DATA_WIDTH{1'b0}};
         tail_r <= {DATA_WIDTH{1'b0}};
         cnt_r  <= 2'd0;
      end else if (clear) begin
         cnt_r  <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (cnt_r == 2'd0) begin
                  head_r <= push_data;
               end else begin
                  tail_r <= push_data;
               end
               cnt_r <= cnt_r + 2'd1;
            end
            2'b01: begin
               head_r <= tail_r;
               cnt_r  <= cnt_r - 2'd1;
            end
            2'b11: begin
               if (cnt_r == 2'd1) begin
                  head_r <= push_data;
               end else begin
                  head_r <= tail_r;
                  tail_r <= push_data;
               end
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   assign head_data = head_r;
   assign cnt       = cnt_r;

endmodule

// File: rtl/sram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around one SRAM bank. Every word
// passes through the bank; a 2-entry prefetch hides the one-cycle read latency.
module sram_fifo_ctrl
   import sram_fifo_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 256,
   parameter int DEPTH      = 32,
   parameter int DUAL_PORT  = DUAL_PORT_OFF,
   parameter int ADDR_WIDTH = ptr_width(DEPTH),
   parameter int CNT_WIDTH  = cnt_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH-1:0] ram_addr_r,
   output logic [ADDR_WIDTH-1:0] ram_addr_w,
   output logic                  ram_read_en,
   output logic                  ram_write_en,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   input  logic [DATA_WIDTH-1:0] ram_data_out,
   output logic [CNT_WIDTH-1:0]  count,
   output logic                  empty,
   output logic                  full
);

   localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

   logic [ADDR_WIDTH-1:0] wr_ptr_r;
   logic [ADDR_WIDTH-1:0] rd_ptr_r;
   logic [CNT_WIDTH-1:0]  ram_cnt_r;
   logic [CNT_WIDTH-1:0]  count_r;
   logic                  rd_inflight_r;
   logic                  ready_en_r;
   logic [1:0]            ob_cnt_s;
   logic [2:0]            ob_occ_s;
   logic                  out_valid_s;
   logic                  pop_s;
   logic                  issue_rd_s;
   logic                  in_ready_s;
   logic                  write_s;

   // Current-cycle handshakes, read issue and single-port arbitration
   always_comb begin
      out_valid_s = (ob_cnt_s != 2'd0);
      pop_s       = out_valid_s && out_ready;
      ob_occ_s    = {1'b0, ob_cnt_s} + {2'b00, rd_inflight_r} - {2'b00, pop_s};
      issue_rd_s  = 1'b0;
      if (!clear && (ram_cnt_r != {CNT_WIDTH{1'b0}}) && (ob_occ_s < 3'(OB_DEPTH))) begin
         issue_rd_s = 1'b1;
      end else begin
         issue_rd_s = 1'b0;
      end
      in_ready_s = ready_en_r && !clear && (ram_cnt_r < DEPTH_C) &&
                   !((DUAL_PORT == DUAL_PORT_OFF) && issue_rd_s);
      write_s    = in_valid && in_ready_s;
   end

   // Pointers, occupancy counters and read-in-flight tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r      <= {ADDR_WIDTH{1'b0}};
         rd_ptr_r      <= {ADDR_WIDTH{1'b0}};
         ram_cnt_r     <= {CNT_WIDTH{1'b0}};
         count_r       <= {CNT_WIDTH{1'b0}};
         rd_inflight_r <= 1'b0;
         ready_en_r    <= 1'b0;
      end else if (clear) begin
         wr_ptr_r      <= {ADDR_WIDTH{1'b0}};
         rd_ptr_r      <= {ADDR_WIDTH{1'b0}};
         ram_cnt_r     <= {CNT_WIDTH{1'b0}};
         count_r       <= {CNT_WIDTH{1'b0}};
         rd_inflight_r <= 1'b0;
         ready_en_r    <= 1'b1;
      end else begin
         ready_en_r    <= 1'b1;
         if (write_s) begin
            wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1'b1);
         end
         if (issue_rd_s) begin
            rd_ptr_r <= rd_ptr_r + ADDR_WIDTH'(1'b1);
         end
         ram_cnt_r     <= ram_cnt_r + CNT_WIDTH'(write_s) - CNT_WIDTH'(issue_rd_s);
         count_r       <= count_r + CNT_WIDTH'(write_s) - CNT_WIDTH'(pop_s);
         rd_inflight_r <= issue_rd_s;
      end
   end

   sram_fifo_prefetch #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_prefetch (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .push      (rd_inflight_r),
      .push_data (ram_data_out),
      .pop       (pop_s),
      .head_data (out_data),
      .cnt       (ob_cnt_s)
   );

   assign in_ready     = in_ready_s;
   assign out_valid    = out_valid_s;
   assign ram_read_en  = issue_rd_s;
   assign ram_write_en = write_s;
   assign ram_addr_r   = rd_ptr_r;
   assign ram_addr_w   = wr_ptr_r;
   assign ram_data_in  = in_data;
   assign count        = count_r;
   assign empty        = (count_r == {CNT_WIDTH{1'b0}});
   assign full         = (ram_cnt_r == DEPTH_C);

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl: one dual-port and one single-port instance share
// stimulus; each has its own bank model and queue-based scoreboard.
module tb_sram_fifo_ctrl;

   localparam int DW    = 32;
   localparam int DEPTH = 32;
   localparam int AW    = 5;
   localparam int CW    = 6;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clear;
   logic          in_valid;
   logic          out_ready;
   logic [DW-1:0] in_data;

   int checks;
   int failures;
   int n_acc;
   int acc0;
   int pop0;
   logic found;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic          in_rdy;
      logic          o_valid;
      logic [DW-1:0] o_data;
      logic [AW-1:0] a_r;
      logic [AW-1:0] a_w;
      logic          re;
      logic          we;
      logic [DW-1:0] wdat;
      logic [DW-1:0] rdat;
      logic [CW-1:0] cnt;
      logic          emp;
      logic          ful;
      logic [DW-1:0] mem [DEPTH];
      logic [DW-1:0] sb_q [$];
      int            acc_n = 0;
      int            pop_n = 0;
      logic          stall_q = 1'b0;
      logic [DW-1:0] stall_d = '0;

      sram_fifo_ctrl #(
         .DATA_WIDTH (DW),
         .DEPTH      (DEPTH),
         .DUAL_PORT  ((g == 0) ? 1 : 0)
      ) u_dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .clear        (clear),
         .in_valid     (in_valid),
         .in_ready     (in_rdy),
         .in_data      (in_data),
         .out_valid    (o_valid),
         .out_ready    (out_ready),
         .out_data     (o_data),
         .ram_addr_r   (a_r),
         .ram_addr_w   (a_w),
         .ram_read_en  (re),
         .ram_write_en (we),
         .ram_data_in  (wdat),
         .ram_data_out (rdat),
         .count        (cnt),
         .empty        (emp),
         .full         (ful)
      );

      // Bank model: one-cycle registered read
      always @(posedge clk) begin
         if (we) mem[a_w] <= wdat;
         if (re) rdat <= mem[a_r];
      end

      // Scoreboard: order, occupancy and stall stability against a queue
      always @(negedge clk) begin
         if (!rst_n) begin
            sb_q.delete();
            stall_q <= 1'b0;
         end else begin
            chk("count", 64'(cnt), 64'(sb_q.size()));
            chk("empty", 64'(emp), 64'(sb_q.size() == 0));
            if (stall_q) begin
               chk("hold_valid", 64'(o_valid), 64'd1);
               chk("hold_data", 64'(o_data), 64'(stall_d));
            end
            if (clear) begin
               sb_q.delete();
               stall_q <= 1'b0;
            end else begin
               if (o_valid && out_ready) begin
                  if (sb_q.size() == 0) begin
                     chk("pop_on_empty_model", 64'd1, 64'd0);
                  end else begin
                     chk("pop_data", 64'(o_data), 64'(sb_q[0]));
                     void'(sb_q.pop_front());
                  end
                  pop_n <= pop_n + 1;
               end
               if (in_valid && in_rdy) begin
                  sb_q.push_back(in_data);
                  acc_n <= acc_n + 1;
               end
               stall_q <= o_valid && !out_ready;
               stall_d <= o_data;
            end
         end
      end
   end

   // Watchdog so a stuck run still ends
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   // Directed and randomized sequence
   initial begin
      checks = 0; failures = 0; n_acc = 0; found = 1'b0;
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready_dp", 64'(g_dut[0].in_rdy), 64'd0);
      chk("rst_in_ready_sp", 64'(g_dut[1].in_rdy), 64'd0);
      chk("rst_out_valid", 64'(g_dut[0].o_valid), 64'd0);
      chk("rst_out_data", 64'(g_dut[0].o_data), 64'd0);
      chk("rst_read_en", 64'(g_dut[0].re), 64'd0);
      chk("rst_write_en", 64'(g_dut[0].we), 64'd0);
      chk("rst_addr_r", 64'(g_dut[0].a_r), 64'd0);
      chk("rst_addr_w", 64'(g_dut[0].a_w), 64'd0);
      chk("rst_count", 64'(g_dut[0].cnt), 64'd0);
      chk("rst_empty", 64'(g_dut[0].emp), 64'd1);
      chk("rst_full", 64'(g_dut[0].ful), 64'd0);
      rst_n = 1'b1;
      tick();
      @(negedge clk);
      chk("post_rst_ready_dp", 64'(g_dut[0].in_rdy), 64'd1);
      chk("post_rst_ready_sp", 64'(g_dut[1].in_rdy), 64'd1);

      // Single word: visible in the third cycle after the accepting edge
      tick();
      in_valid = 1'b1; in_data = 32'h0000_00A5;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat_e0_dp", 64'(g_dut[0].o_valid), 64'd0);
      tick();
      @(negedge clk);
      chk("lat_e1_dp", 64'(g_dut[0].o_valid), 64'd0);
      chk("lat_e1_sp", 64'(g_dut[1].o_valid), 64'd0);
      tick();
      @(negedge clk);
      chk("lat_e2_valid_dp", 64'(g_dut[0].o_valid), 64'd1);
      chk("lat_e2_data_dp", 64'(g_dut[0].o_data), 64'h0A5);
      chk("lat_e2_count_dp", 64'(g_dut[0].cnt), 64'd1);
      chk("lat_e2_valid_sp", 64'(g_dut[1].o_valid), 64'd1);
      tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      @(negedge clk);
      chk("single_count0", 64'(g_dut[0].cnt), 64'd0);
      chk("single_empty", 64'(g_dut[0].emp), 64'd1);
      chk("single_valid0", 64'(g_dut[0].o_valid), 64'd0);

      // Fill: 40 offered, DEPTH+2 accepted
      for (int i = 0; i < 40; i++) begin
         tick();
         in_valid = 1'b1; in_data = DW'(i);
         @(negedge clk);
         if (g_dut[0].in_rdy) n_acc++;
      end
      tick();
      in_valid = 1'b0;
      repeat (2) tick();
      @(negedge clk);
      chk("fill_accepted", 64'(n_acc), 64'd34);
      chk("fill_full", 64'(g_dut[0].ful), 64'd1);
      chk("fill_in_ready", 64'(g_dut[0].in_rdy), 64'd0);
      chk("fill_count_dp", 64'(g_dut[0].cnt), 64'd34);
      chk("fill_count_sp", 64'(g_dut[1].cnt), 64'd34);

      // Drain in order at one word per cycle
      for (int i = 0; i < 34; i++) begin
         tick();
         out_ready = 1'b1;
         @(negedge clk);
         chk("drain_valid", 64'(g_dut[0].o_valid), 64'd1);
         chk("drain_data", 64'(g_dut[0].o_data), 64'(i));
      end
      repeat (4) tick();
      @(negedge clk);
      chk("drain_empty_dp", 64'(g_dut[0].emp), 64'd1);
      chk("drain_empty_sp", 64'(g_dut[1].emp), 64'd1);

      // Streaming across pointer wrap, dual-port at full rate
      for (int c = 0; c < 103; c++) begin
         tick();
         in_valid = (c < 100); in_data = DW'(1000 + c); out_ready = 1'b1;
         @(negedge clk);
         if (c < 100) chk("wrap_in_ready", 64'(g_dut[0].in_rdy), 64'd1);
         if (c >= 3) begin
            chk("wrap_valid", 64'(g_dut[0].o_valid), 64'd1);
            chk("wrap_data", 64'(g_dut[0].o_data), 64'(1000 + c - 3));
         end
      end
      tick();
      in_valid = 1'b0;
      repeat (10) tick();
      @(negedge clk);
      chk("sp_pre_empty", 64'(g_dut[1].emp), 64'd1);

      // Single-port continuous traffic
      acc0 = g_dut[1].acc_n; pop0 = g_dut[1].pop_n;
      for (int c = 0; c < 60; c++) begin
         tick();
         in_valid = 1'b1; in_data = DW'(2000 + c); out_ready = 1'b1;
         @(negedge clk);
         chk("sp_port_excl", 64'(g_dut[1].re && g_dut[1].we), 64'd0);
      end
      tick();
      in_valid = 1'b0;
      repeat (10) tick();
      @(negedge clk);
      chk("sp_no_loss", 64'(g_dut[1].acc_n - acc0), 64'(g_dut[1].pop_n - pop0));
      chk("sp_progress", 64'((g_dut[1].acc_n - acc0) >= 25), 64'd1);
      chk("sp_empty_after", 64'(g_dut[1].emp), 64'd1);

      // Random traffic with 50% backpressure
      for (int c = 0; c < 300; c++) begin
         tick();
         in_valid = ($urandom_range(0, 9) < 7);
         in_data = DW'($urandom);
         out_ready = ($urandom_range(0, 1) == 1);
         @(negedge clk);
         chk("rnd_sp_excl", 64'(g_dut[1].re && g_dut[1].we), 64'd0);
      end
      tick();
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (80) tick();
      @(negedge clk);
      chk("rnd_empty_dp", 64'(g_dut[0].emp), 64'd1);
      chk("rnd_empty_sp", 64'(g_dut[1].emp), 64'd1);

      // Clear with a read in flight and five words held
      tick();
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_data = DW'(32'h300 + i);
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("clr_issue", 64'(g_dut[0].re), 64'd1);
      chk("clr_head", 64'(g_dut[0].o_data), 64'h300);
      tick();
      out_ready = 1'b0; clear = 1'b1; in_valid = 1'b1; in_data = 32'h55;
      @(negedge clk);
      chk("clr_count5", 64'(g_dut[0].cnt), 64'd5);
      chk("clr_no_read", 64'(g_dut[0].re), 64'd0);
      chk("clr_no_write", 64'(g_dut[0].we), 64'd0);
      chk("clr_no_ready", 64'(g_dut[0].in_rdy), 64'd0);
      chk("clr_sp_no_strobe", 64'(g_dut[1].re || g_dut[1].we), 64'd0);
      tick();
      clear = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("clr_count0", 64'(g_dut[0].cnt), 64'd0);
      chk("clr_valid0", 64'(g_dut[0].o_valid), 64'd0);
      chk("clr_empty", 64'(g_dut[0].emp), 64'd1);
      tick();
      in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      found = 1'b0;
      for (int w = 0; w < 8; w++) begin
         @(negedge clk);
         if (!found && g_dut[0].o_valid) begin
            found = 1'b1;
            chk("clr_first_word", 64'(g_dut[0].o_data), 64'h77);
         end
         tick();
      end
      chk("clr_word_seen", 64'(found), 64'd1);
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sram_fifo_ctrl.md
# sram_fifo_ctrl

First-word-fall-through FIFO controller that wraps one on-chip SRAM bank instance with a valid/ready stream interface. It sits directly upstream of the RAM wrapper: it drives the bank's read/write ports, absorbs the one-cycle read latency with a 2-entry prefetch buffer, and presents a stall-free output stream to the consumer. It is used for the GLB/shuffle streaming buffers in both single-port and dual-port bank configurations.

## Interface
- DATA_WIDTH, 256, word width; must equal the bank's SRAM_BIT*SRAM_BYTE
- DEPTH, 32, bank words; power of two, ≥ 2
- DUAL_PORT, 0, 1 = bank accepts a read and a write in the same cycle; 0 = one access per cycle
- ADDR_WIDTH, $clog2(DEPTH), bank address width
- CNT_WIDTH, $clog2(DEPTH+3), occupancy counter width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous flush; wins over all other activity
- in_valid / in_ready  in / out  1 / 1  write-side handshake
- in_data  in  DATA_WIDTH  write word
- out_valid / out_ready  out / in  1 / 1  read-side handshake
- out_data  out  DATA_WIDTH  head word, held stable while out_valid && !out_ready
- ram_addr_r / ram_addr_w  out  ADDR_WIDTH  bank read/write address
- ram_read_en / ram_write_en  out  1  bank strobes
- ram_data_in  out  DATA_WIDTH  bank write data (= in_data)
- ram_data_out  in  DATA_WIDTH  bank read data, valid the cycle after ram_read_en
- count  out  CNT_WIDTH  total words held (bank + in-flight + prefetch)
- empty / full  out  1  count==0 / bank full

## Operation
- State: wr_ptr, rd_ptr (ADDR_WIDTH, wrap modulo DEPTH), ram_cnt (0..DEPTH), rd_inflight (1 bit), ob (2-entry prefetch FIFO, ob_cnt 0..2).
- Write: in_ready = !clear && ram_cnt<DEPTH && !(DUAL_PORT==0 && issue_rd). ram_write_en = in_valid && in_ready; ram_addr_w = wr_ptr; wr_ptr++ on write.
- Read issue: issue_rd = !clear && ram_cnt>0 && (ob_cnt + rd_inflight − pop) < 2, where pop = out_valid && out_ready. ram_read_en = issue_rd; ram_addr_r = rd_ptr; rd_ptr++; rd_inflight <= issue_rd.
- Single-port arbitration: read has priority; in_ready drops in issue cycles. No deadlock: reads issue only while prefetch has room.
- Capture: when rd_inflight, ram_data_out is pushed into ob at that edge; simultaneous pop and push allowed.
- ram_cnt next = ram_cnt + write − issue_rd. count next = count + write − pop.
- No bypass: a word always traverses the bank, even when empty.
- clear: pointers, ram_cnt, ob_cnt, rd_inflight, count → 0 next edge; in-flight data dropped; no bank strobes asserted that cycle.
- Reset mid-operation: same as clear, asynchronously; bank contents undefined and ignored.

## Timing
- Reset values: in_ready 0 while rst_n low, 1 first cycle after release; out_valid 0; out_data 0; ram_read_en 0; ram_write_en 0; addresses 0; count 0; empty 1; full 0.
- Latency: word accepted at edge E0 → read issued cycle after E0 → captured at E2 → out_valid high after E2 (2 cycles after acceptance edge).
- Steady-state throughput 1 word/cycle with DUAL_PORT=1; with DUAL_PORT=0 writes and reads share the port (≤1 access/cycle total).
- Full: ram_cnt==DEPTH ⇒ in_ready 0; total capacity DEPTH+2.
- out_valid never drops without a pop; out_data changes only on pop or from empty.

## Structure
- Shared package: ptr/count width functions and DUAL_PORT encoding constants.
- One natural sub-module: sram_fifo_prefetch (2-entry skid FIFO with push/pop/cnt).
- Bank instance is outside this block; the parent connects ram_* to the RAM wrapper.

## Test plan
- Single word, DUAL_PORT=1: in_data=0xA5 accepted at E0 → out_valid after E2 with 0xA5, count=1 then 0 after pop; empty returns 1.
- Fill: out_ready=0, push 40 words into DEPTH=32 → exactly 34 accepted, full=1, in_ready=0, count=34; drain returns 0..33 in order.
- Wrap: 100 words streaming with out_ready=1, DUAL_PORT=1 → 1 word/cycle after 2-cycle fill, data in order across pointer wrap.
- Single-port: DUAL_PORT=0, continuous in_valid and out_ready → ram_read_en and ram_write_en never both 1; in order, no loss.
- Backpressure: random out_ready (50%) → out_data stable while stalled, no duplicates/drops, scoreboard match.
- clear with rd_inflight=1 and count=5 → next cycle count=0, out_valid=0, empty=1; next pushed word 0x77 emerges first.
